// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the MiniMIPS core with load-use hazard detection.
// Latency: one cycle from the ID inputs to the ex_* outputs. The stall output is combinational.
// Backpressure: on a load-use hazard, stall holds PC and IF/ID and a bubble goes into EX.
//   A branch flush always loads a bubble.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   id_valid, id_instr  ID-stage instruction and its valid flag
//   id_pc_plus4         PC+4 of the ID instruction
//   id_rd1, id_rd2      register file read data for rs and rt
//   id_ctrl             decoder control bundle (packing given in ctrl_t below)
//   flush               branch taken; kill the ID instruction
//   stall               load-use stall to PC and IF/ID
//   ex_*                registered fields presented to EX
//   stall_count         saturating count of cycles lost to load-use stalls
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [DATA_WIDTH-1:0] id_pc_plus4,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [9:0]            id_ctrl,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc_plus4,
  output logic [DATA_WIDTH-1:0] ex_rd1,
  output logic [DATA_WIDTH-1:0] ex_rd2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [ADDR_WIDTH-1:0] ex_rs,
  output logic [ADDR_WIDTH-1:0] ex_rt,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic [9:0]            ex_ctrl,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  ctrl_t                 ex_ctrl_q;
  logic [ADDR_WIDTH-1:0] id_rs;
  logic [ADDR_WIDTH-1:0] id_rt;
  logic [ADDR_WIDTH-1:0] id_rd;
  logic [DATA_WIDTH-1:0] id_imm;
  logic                  rt_hit;
  logic                  bubble;
  logic                  unused_opcode;

  assign id_rs  = ADDR_WIDTH'(id_instr[25:21]);
  assign id_rt  = ADDR_WIDTH'(id_instr[20:16]);
  assign id_rd  = ADDR_WIDTH'(id_instr[15:11]);
  assign id_imm = {{(DATA_WIDTH-16){id_instr[15]}}, id_instr[15:0]};

  // The opcode is consumed by the decoder upstream; it plays no role here.
  assign unused_opcode = ^id_instr[31:26];

  // rt is compared even for I-type consumers whose rt is a destination.
  // The extra stall this can cause is conservative and harmless.
  assign rt_hit = (ex_rt == id_rs) || (ex_rt == id_rt);

  // A load into $zero never produces a value, so it cannot create a hazard.
  // After the bubble, ex_ctrl is zero, so a load-use pair stalls for exactly one cycle.
  assign stall = id_valid && ex_valid && ex_ctrl_q.mem_read &&
                 (ex_rt != '0) && rt_hit;

  assign bubble  = flush || stall;
  assign ex_ctrl = ex_ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc_plus4 <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_ctrl_q   <= '0;
      stall_count <= '0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_pc_plus4 <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_ctrl_q   <= '0;
      // A flush kills the instruction anyway, so no cycle is lost to the hazard.
      if (!flush && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_WIDTH'(1);
      end
    end else begin
      ex_valid    <= id_valid;
      ex_pc_plus4 <= id_pc_plus4;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_ctrl_q   <= id_valid ? ctrl_t'(id_ctrl) : ctrl_t'('0);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam logic [31:0] I_ADD_T3_T1_T2 = 32'h012A5820; // add $t3,$t1,$t2
  localparam logic [31:0] I_ADD_T3_T0_T2 = 32'h010A5820; // add $t3,$t0,$t2
  localparam logic [31:0] I_LW_T0        = 32'h8D280000; // lw  $t0,0($t1)
  localparam logic [31:0] I_LW_ZERO      = 32'h8D200000; // lw  $zero,0($t1)
  localparam logic [31:0] I_ADD_ZERO     = 32'h00005820; // add $t3,$zero,$zero
  localparam logic [31:0] I_ADDI_NEG4    = 32'h2128FFFC; // addi $t0,$t1,-4
  localparam logic [31:0] I_ADDI_POS4    = 32'h21280004; // addi $t0,$t1,4
  localparam logic [9:0]  C_ADD  = 10'b1_0_0_0_0_0_1_010;
  localparam logic [9:0]  C_LW   = 10'b1_1_0_1_0_1_0_010;
  localparam logic [9:0]  C_ADDI = 10'b1_0_0_0_0_1_0_010;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr, id_pc_plus4, id_rd1, id_rd2;
  logic [9:0]  id_ctrl;
  logic        flush;

  logic        stall, ex_valid;
  logic [31:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [9:0]  ex_ctrl;
  logic [15:0] stall_count;

  logic        s_stall, s_ex_valid;
  logic [31:0] s_ex_pc_plus4, s_ex_rd1, s_ex_rd2, s_ex_imm;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [9:0]  s_ex_ctrl;
  logic [1:0]  s_stall_count;

  always #5 clk = ~clk;

  id_ex_stage u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_ctrl(id_ctrl), .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_ctrl(id_ctrl), .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid),
    .ex_pc_plus4(s_ex_pc_plus4), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2),
    .ex_imm(s_ex_imm), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
    .ex_ctrl(s_ex_ctrl), .stall_count(s_stall_count)
  );

  typedef struct {
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what EX should hold after the last edge.
  logic        m_valid;
  logic [9:0]  m_ctrl;
  logic [4:0]  m_rt;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ctrl  = '0;
    m_rt    = '0;
    m_cnt   = '0;
    m_cnt2  = '0;
  endtask

  // Drive one ID cycle, check the combinational stall, queue the expected EX
  // contents, then clock and compare against the oldest queued entry.
  task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [9:0] ctrl, input logic fl);
    logic m_stall;
    exp_t e;
    exp_t g;
    id_valid    = v;
    id_instr    = instr;
    id_pc_plus4 = 32'h0040_0000 + {instr[7:0], 2'b00};
    id_rd1      = rd1;
    id_rd2      = rd2;
    id_ctrl     = ctrl;
    flush       = fl;
    #1;
    m_stall = v && m_valid && m_ctrl[6] && (m_rt != 5'd0) &&
              ((m_rt == instr[25:21]) || (m_rt == instr[20:16]));
    chk("stall", stall, m_stall);
    if (fl || m_stall) begin
      e = '{valid: 1'b0, ctrl: '0, pc4: '0, rd1: '0, rd2: '0, imm: '0,
            rs: '0, rt: '0, rd: '0, cnt: m_cnt, cnt2: m_cnt2};
      if (!fl) begin
        if (m_cnt != 16'hFFFF) e.cnt = m_cnt + 16'd1;
        if (m_cnt2 != 2'b11)   e.cnt2 = m_cnt2 + 2'd1;
      end
    end else begin
      e = '{valid: v, ctrl: (v ? ctrl : 10'd0), pc4: id_pc_plus4, rd1: rd1, rd2: rd2,
            imm: {{16{instr[15]}}, instr[15:0]}, rs: instr[25:21], rt: instr[20:16],
            rd: instr[15:11], cnt: m_cnt, cnt2: m_cnt2};
    end
    sb.push_back(e);
    m_valid = e.valid;
    m_ctrl  = e.ctrl;
    m_rt    = e.rt;
    m_cnt   = e.cnt;
    m_cnt2  = e.cnt2;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
    end else begin
      g = sb.pop_front();
      chk("ex_valid", ex_valid, g.valid);
      chk("ex_ctrl", ex_ctrl, g.ctrl);
      chk("ex_pc_plus4", ex_pc_plus4, g.pc4);
      chk("ex_rd1", ex_rd1, g.rd1);
      chk("ex_rd2", ex_rd2, g.rd2);
      chk("ex_imm", ex_imm, g.imm);
      chk("ex_rs", ex_rs, g.rs);
      chk("ex_rt", ex_rt, g.rt);
      chk("ex_rd", ex_rd, g.rd);
      chk("stall_count", stall_count, g.cnt);
      chk("sat_stall_count", s_stall_count, g.cnt2);
    end
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_instr = '0; id_pc_plus4 = '0;
    id_rd1 = '0; id_rd2 = '0; id_ctrl = '0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_stall_count", stall_count, 16'd0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // Normal capture
    cycle(1'b1, I_ADD_T3_T1_T2, 32'd5, 32'd7, C_ADD, 1'b0);
    chk("add_rd1", ex_rd1, 32'd5);
    chk("add_rs", ex_rs, 5'd9);
    chk("add_rt", ex_rt, 5'd10);
    chk("add_rd", ex_rd, 5'd11);
    chk("add_valid", ex_valid, 1'b1);

    // Sign extension, both polarities
    cycle(1'b1, I_ADDI_NEG4, 32'd1, 32'd2, C_ADDI, 1'b0);
    chk("imm_neg", ex_imm, 32'hFFFF_FFFC);
    cycle(1'b1, I_ADDI_POS4, 32'd3, 32'd4, C_ADDI, 1'b0);
    chk("imm_pos", ex_imm, 32'h0000_0004);

    // Invalid ID slot: control must be zeroed
    cycle(1'b0, I_ADD_T3_T1_T2, 32'd9, 32'd9, C_ADD, 1'b0);
    chk("invalid_ctrl", ex_ctrl, 10'd0);

    // Load-use: one stall cycle, then the add is captured
    cycle(1'b1, I_LW_T0, 32'h100, 32'd0, C_LW, 1'b0);
    cycle(1'b1, I_ADD_T3_T0_T2, 32'd11, 32'd12, C_ADD, 1'b0);
    chk("lu_bubble_ctrl", ex_ctrl, 10'd0);
    chk("lu_count", stall_count, 16'd1);
    cycle(1'b1, I_ADD_T3_T0_T2, 32'd11, 32'd12, C_ADD, 1'b0);
    chk("lu_add_valid", ex_valid, 1'b1);
    chk("lu_add_rd1", ex_rd1, 32'd11);

    // Load to $zero never stalls
    cycle(1'b1, I_LW_ZERO, 32'h100, 32'd0, C_LW, 1'b0);
    cycle(1'b1, I_ADD_ZERO, 32'd0, 32'd0, C_ADD, 1'b0);
    chk("zero_no_stall_count", stall_count, 16'd1);

    // Flush coinciding with a stall: bubble, count unchanged
    cycle(1'b1, I_LW_T0, 32'h100, 32'd0, C_LW, 1'b0);
    cycle(1'b1, I_ADD_T3_T0_T2, 32'd1, 32'd2, C_ADD, 1'b1);
    chk("flush_count", stall_count, 16'd1);
    chk("flush_valid", ex_valid, 1'b0);

    // Plain flush of a normal instruction
    cycle(1'b1, I_ADD_T3_T1_T2, 32'd5, 32'd7, C_ADD, 1'b0);
    cycle(1'b1, I_ADDI_NEG4, 32'd5, 32'd7, C_ADDI, 1'b1);

    // Five load-use pairs saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, I_LW_T0, 32'h200 + i, 32'd0, C_LW, 1'b0);
      cycle(1'b1, I_ADD_T3_T0_T2, i, i + 1, C_ADD, 1'b0);
      cycle(1'b1, I_ADD_T3_T0_T2, i, i + 1, C_ADD, 1'b0);
    end
    chk("sat_count", s_stall_count, 2'd3);
    chk("wide_count", stall_count, 16'd6);

    // Asynchronous reset mid-cycle while a stall is pending
    cycle(1'b1, I_LW_T0, 32'h300, 32'd0, C_LW, 1'b0);
    id_instr = I_ADD_T3_T0_T2;
    id_ctrl  = C_ADD;
    id_valid = 1'b1;
    #1;
    chk("pre_rst_stall", stall, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", ex_valid, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_ctrl", ex_ctrl, 10'd0);
    chk("mid_rst_rd1", ex_rd1, 32'd0);
    chk("mid_rst_count", stall_count, 16'd0);
    chk("mid_rst_sat_count", s_stall_count, 2'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, I_ADD_T3_T1_T2, 32'd5, 32'd7, C_ADD, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage MiniMIPS core.
- Captures the register-file read data (RD1/RD2), decoded instruction fields, the sign-extended immediate and the control bundle from the decoder. Presents them registered to EX.
- Contains load-use hazard detection: it drives a stall to PC/IF-ID and inserts a bubble. It also honours a branch flush and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_WIDTH, 32, datapath width.
- ADDR_WIDTH, 5, register specifier width.
- CNT_WIDTH, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_instr  in  32  instruction word in ID.
- id_pc_plus4  in  DATA_WIDTH  PC+4 of the ID instruction.
- id_rd1  in  DATA_WIDTH  register file RD1 (rs).
- id_rd2  in  DATA_WIDTH  register file RD2 (rt).
- id_ctrl  in  10  {reg_write, mem_to_reg, mem_write, mem_read, branch, alu_src, reg_dst, alu_ctrl[2:0]}.
- flush  in  1  branch taken; kill the ID instruction.
- stall  out  1  combinational load-use stall; holds PC and IF/ID.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc_plus4  out  DATA_WIDTH  registered PC+4.
- ex_rd1  out  DATA_WIDTH  registered rs data.
- ex_rd2  out  DATA_WIDTH  registered rt data.
- ex_imm  out  DATA_WIDTH  sign-extended instr[15:0].
- ex_rs  out  ADDR_WIDTH  instr[25:21].
- ex_rt  out  ADDR_WIDTH  instr[20:16].
- ex_rd  out  ADDR_WIDTH  instr[15:11].
- ex_ctrl  out  10  registered control bundle, same packing as id_ctrl.
- stall_count  out  CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- Reset: while rst is high, every ex_* output, ex_valid and stall_count are 0, asynchronously. stall evaluates to 0 because ex_valid=0.
- Stall condition is combinational:
  - stall = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rt != 0) & (ex_rt == id_instr[25:21] | ex_rt == id_instr[20:16]).
  - Comparing rt unconditionally is intentional: it gives a conservative extra stall for I-type ops and is accepted.
- Update priority at posedge clk: flush > stall > normal.
- flush: load a bubble. ex_valid=0 and ex_ctrl=0; data fields are don't-care but must be driven to 0. flush with stall in the same cycle produces a bubble, and stall_count does not increment.
- stall (no flush): load a bubble as above and increment stall_count, saturating at all-ones. The ID inputs are held upstream and re-presented next cycle.
- Normal: capture all fields.
  - ex_valid = id_valid.
  - ex_ctrl = id_valid ? id_ctrl : 0.
  - ex_imm = {{(DATA_WIDTH-16){id_instr[15]}}, id_instr[15:0]}.
- Latency: one cycle from ID to EX. A load-use pair costs exactly 1 stall cycle, because after the bubble ex_ctrl.mem_read=0 and stall deasserts.
- $zero: ex_rt==0 never stalls.
- Writeback bypass: WB-to-ID forwarding is not needed here, since the register file writes on negedge and ID reads post-write data in the same cycle.
- Back-to-back loads: each dependent consumer stalls independently. Two stalls are never generated for one pair.
- Reset mid-stall: stall drops immediately because ex_valid is cleared asynchronously.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all outputs 0 immediately, stall=0, stall_count=0.
- Normal capture: id_rd1=5, id_rd2=7, instr=add $t3,$t1,$t2 (0x012A5820), id_ctrl reg_write=1, alu_ctrl=010 -> next cycle ex_rd1=5, ex_rd2=7, ex_rs=9, ex_rt=10, ex_rd=11, ex_valid=1.
- Sign-extension: instr imm field 0xFFFC -> ex_imm=0xFFFFFFFC; imm 0x0004 -> 0x00000004.
- Load-use: lw $t0,0($t1) in EX, add $t3,$t0,$t2 in ID -> stall=1 for exactly one cycle, bubble with ex_ctrl=0, stall_count 0->1; next cycle the add is captured.
- $zero and flush:
  - lw to $zero followed by a use of $zero -> stall=0.
  - flush=1 together with a stall condition -> bubble, stall_count unchanged.
- Saturation: CNT_WIDTH=2 with 5 consecutive load-use pairs -> stall_count stops at 3.
